// File: rtl/sc_spi_arb.sv
// Round-robin arbiter that shares one SPI engine between NREQ requesters, keeping
// the engine locked to a single requester for the whole multi-word transaction.
module sc_spi_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic               SYSCLK,
  input  logic               SYSRST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*32-1:0] REQ_DATA,
  input  logic [NREQ-1:0]    REQ_LAST,
  output logic [NREQ-1:0]    ACK,
  output logic [NREQ-1:0]    RSP_VALID,
  output logic [31:0]        RSP_DATA,
  output logic               RSP_ERR,
  output logic [NREQ-1:0]    GNT,
  output logic               ARB_BUSY,
  output logic               ENG_TXSTART,
  output logic [31:0]        ENG_TXDATA,
  output logic               ENG_CSEXTEND,
  input  logic               ENG_SPIBUSY,
  input  logic               ENG_SPICOMPLETE,
  input  logic [31:0]        ENG_RXDATA
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_NEXT = 2'd2
  } state_t;

  state_t          r_state,     w_state_next;
  logic [IW-1:0]   r_pri,       w_pri_next;
  logic [IW-1:0]   r_owner,     w_owner_next;
  logic [15:0]     r_cnt,       w_cnt_next;
  logic            r_last,      w_last_next;
  logic [NREQ-1:0] r_ack,       w_ack_next;
  logic [NREQ-1:0] r_rsp_valid, w_rsp_valid_next;
  logic [31:0]     r_rsp_data,  w_rsp_data_next;
  logic            r_rsp_err,   w_rsp_err_next;
  logic            r_txstart,   w_txstart_next;
  logic [31:0]     r_txdata,    w_txdata_next;
  logic            r_csext,     w_csext_next;

  logic [IW-1:0]   w_win;
  logic            w_found;
  logic [IW-1:0]   w_owner_inc;
  logic            w_issue;
  logic [IW-1:0]   w_issue_sel;
  int              w_idx;

  // First asserted request at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_pri;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_pri) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && REQ[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  assign w_owner_inc = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);

  always_comb begin
    w_state_next     = r_state;
    w_pri_next       = r_pri;
    w_owner_next     = r_owner;
    w_cnt_next       = r_cnt;
    w_last_next      = r_last;
    w_ack_next       = '0;
    w_rsp_valid_next = '0;
    w_rsp_data_next  = r_rsp_data;
    w_rsp_err_next   = r_rsp_err;
    w_txstart_next   = 1'b0;
    w_txdata_next    = r_txdata;
    w_csext_next     = r_csext;
    w_issue          = 1'b0;
    w_issue_sel      = r_owner;

    unique case (r_state)
      S_IDLE: begin
        if (w_found && !ENG_SPIBUSY) begin
          w_issue     = 1'b1;
          w_issue_sel = w_win;
        end
      end
      S_WAIT: begin
        // A completion on the expiry cycle still counts as a good word.
        if (ENG_SPICOMPLETE) begin
          w_rsp_valid_next[r_owner] = 1'b1;
          w_rsp_data_next           = ENG_RXDATA;
          w_rsp_err_next            = 1'b0;
          if (r_last) begin
            w_pri_next   = w_owner_inc;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_NEXT;
          end
        end else if (r_cnt == 16'(TIMEOUT - 1)) begin
          w_rsp_valid_next[r_owner] = 1'b1;
          w_rsp_data_next           = '0;
          w_rsp_err_next            = 1'b1;
          w_pri_next                = w_owner_inc;
          w_state_next              = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_NEXT: begin
        if (REQ[r_owner] && !ENG_SPIBUSY) begin
          w_issue     = 1'b1;
          w_issue_sel = r_owner;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_issue) begin
      w_txdata_next            = REQ_DATA[32*w_issue_sel +: 32];
      w_csext_next             = ~REQ_LAST[w_issue_sel];
      w_last_next              = REQ_LAST[w_issue_sel];
      w_txstart_next           = 1'b1;
      w_ack_next[w_issue_sel]  = 1'b1;
      w_owner_next             = w_issue_sel;
      w_cnt_next               = '0;
      w_state_next             = S_WAIT;
    end
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      r_state     <= S_IDLE;
      r_pri       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_ack       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_txstart   <= 1'b0;
      r_txdata    <= '0;
      r_csext     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pri       <= w_pri_next;
      r_owner     <= w_owner_next;
      r_cnt       <= w_cnt_next;
      r_last      <= w_last_next;
      r_ack       <= w_ack_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_rsp_err   <= w_rsp_err_next;
      r_txstart   <= w_txstart_next;
      r_txdata    <= w_txdata_next;
      r_csext     <= w_csext_next;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    assign GNT[gi] = (r_state != S_IDLE) && (r_owner == IW'(gi));
  end

  assign ARB_BUSY     = (r_state != S_IDLE);
  assign ACK          = r_ack;
  assign RSP_VALID    = r_rsp_valid;
  assign RSP_DATA     = r_rsp_data;
  assign RSP_ERR      = r_rsp_err;
  assign ENG_TXSTART  = r_txstart;
  assign ENG_TXDATA   = r_txdata;
  assign ENG_CSEXTEND = r_csext;

endmodule

// File: tb/tb_sc_spi_arb.sv
// Self-checking bench for sc_spi_arb: directed scenarios then random traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_sc_spi_arb;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*32-1:0] req_data = '0;
  logic [NREQ-1:0]    req_last = '0;
  logic [NREQ-1:0]    ack, rsp_valid, gnt;
  logic [31:0]        rsp_data, txdata;
  logic               rsp_err, arb_busy, txstart, csext;
  logic               spibusy = 1'b0;
  logic               spicomplete = 1'b0;
  logic [31:0]        rxdata = '0;

  sc_spi_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .SYSCLK          (clk),
    .SYSRST          (rst),
    .REQ             (req),
    .REQ_DATA        (req_data),
    .REQ_LAST        (req_last),
    .ACK             (ack),
    .RSP_VALID       (rsp_valid),
    .RSP_DATA        (rsp_data),
    .RSP_ERR         (rsp_err),
    .GNT             (gnt),
    .ARB_BUSY        (arb_busy),
    .ENG_TXSTART     (txstart),
    .ENG_TXDATA      (txdata),
    .ENG_CSEXTEND    (csext),
    .ENG_SPIBUSY     (spibusy),
    .ENG_SPICOMPLETE (spicomplete),
    .ENG_RXDATA      (rxdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester word queues (circular, index modulo 64).
  logic [31:0] fb_data [NREQ][64];
  logic        fb_last [NREQ][64];
  int          fb_head [NREQ];
  int          fb_tail [NREQ];

  // Engine stand-in controls.
  bit          e_pend = 1'b0;
  int          e_cnt = 0;
  int          fixed_delay = 0;
  bit          use_fixed_rx = 1'b0;
  logic [31:0] fixed_rx = '0;
  int          busy_prob = 0;
  int          stray_prob = 0;
  int          req_prob = 100;
  bit          force_busy = 1'b0;

  // Reference model: pointer, lock owner (-1 = unlocked), word in flight and its age.
  int          m_pri = 0, m_lock = -1, m_own = 0, m_age = 0;
  bit          m_inflight = 1'b0, m_last = 1'b0, m_csext = 1'b0;
  logic [31:0] m_txdata = '0;

  int          grant_log[$];
  int          cs_log[$];
  int          rsp_cnt = 0;
  logic [31:0] last_rsp_data = '0;
  logic        last_rsp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qcount(input int r);
    return fb_tail[r] - fb_head[r];
  endfunction

  task automatic push(input int r, input logic [31:0] d, input logic l);
    fb_data[r][fb_tail[r] % 64] = d;
    fb_last[r][fb_tail[r] % 64] = l;
    fb_tail[r]++;
  endtask

  function automatic bit anything_pending();
    bit p = e_pend || m_inflight || (m_lock >= 0);
    for (int r = 0; r < NREQ; r++)
      if (qcount(r) > 0 || req[r]) p = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_pri = 0; m_lock = -1; m_own = 0; m_age = 0;
    m_inflight = 1'b0; m_last = 1'b0; m_csext = 1'b0; m_txdata = '0;
  endtask

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      if (ack[r]) begin
        fb_head[r]++;
        req[r] = 1'b0;
      end
      if (!req[r] && qcount(r) > 0 && $urandom_range(99) < req_prob) req[r] = 1'b1;
      if (qcount(r) > 0) begin
        req_data[32*r +: 32] = fb_data[r][fb_head[r] % 64];
        req_last[r]          = fb_last[r][fb_head[r] % 64];
      end
    end
    spicomplete = 1'b0;
    if (txstart) begin
      e_pend = 1'b1;
      e_cnt  = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 20));
    end
    if (e_pend) begin
      e_cnt--;
      if (e_cnt == 0) begin
        spicomplete = 1'b1;
        rxdata      = use_fixed_rx ? fixed_rx : $urandom;
        e_pend      = 1'b0;
      end
    end else if ($urandom_range(99) < stray_prob) begin
      spicomplete = 1'b1;
      rxdata      = $urandom;
    end
    spibusy = force_busy || e_pend || ($urandom_range(99) < busy_prob);
  endtask

  // One clock: sample inputs at the edge, predict, compare just after the edge, then drive.
  task automatic step();
    logic [NREQ-1:0]    c_req, c_last;
    logic [NREQ*32-1:0] c_data;
    logic               c_busy, c_cmp, e_start, e_err;
    logic [31:0]        c_rx, e_rd;
    logic [NREQ-1:0]    e_ack, e_rv;
    int                 w;
    @(posedge clk);
    c_req = req; c_last = req_last; c_data = req_data;
    c_busy = spibusy; c_cmp = spicomplete; c_rx = rxdata;
    #1;
    e_ack = '0; e_rv = '0; e_start = 1'b0; e_err = 1'b0; e_rd = '0;
    if (m_inflight) begin
      if (c_cmp) begin
        e_rv[m_own] = 1'b1; e_rd = c_rx; e_err = 1'b0; m_inflight = 1'b0;
        if (m_last) begin
          m_lock = -1; m_pri = (m_own + 1) % NREQ;
        end
      end else if (m_age == TIMEOUT - 1) begin
        e_rv[m_own] = 1'b1; e_rd = '0; e_err = 1'b1; m_inflight = 1'b0;
        m_lock = -1; m_pri = (m_own + 1) % NREQ;
      end else begin
        m_age++;
      end
    end else if (!c_busy) begin
      w = -1;
      if (m_lock >= 0) begin
        if (c_req[m_lock]) w = m_lock;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && c_req[(m_pri + k) % NREQ]) w = (m_pri + k) % NREQ;
      end
      if (w >= 0) begin
        e_ack[w] = 1'b1; e_start = 1'b1;
        m_txdata = c_data[32*w +: 32]; m_csext = !c_last[w]; m_last = c_last[w];
        m_inflight = 1'b1; m_age = 0; m_own = w; m_lock = w;
      end
    end
    check("ack", ack, e_ack);
    check("rsp_valid", rsp_valid, e_rv);
    check("txstart", txstart, e_start);
    check("gnt", gnt, (m_inflight || m_lock >= 0) ? NREQ'(1 << m_own) : '0);
    check("arb_busy", arb_busy, m_inflight || m_lock >= 0);
    check("txdata", txdata, m_txdata);
    check("csextend", csext, m_csext);
    if (e_rv != 0) begin
      check("rsp_data", rsp_data, e_rd);
      check("rsp_err", rsp_err, e_err);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (ack[k]) grant_log.push_back(k);
      if (rsp_valid[k]) begin
        rsp_cnt++; last_rsp_data = rsp_data; last_rsp_err = rsp_err;
        $display("txn rsp req=%0d data=%08h err=%0d t=%0t", k, rsp_data, rsp_err, $time);
      end
    end
    if (txstart) cs_log.push_back(int'(csext));
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int limit);
    int n = 0;
    while (anything_pending() && n < limit) begin
      step();
      n++;
    end
    check(tag, n < limit, 1'b1);
    repeat (3) step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_busy"}, arb_busy, 0);
    check({tag, "_txstart"}, txstart, 0);
    check({tag, "_txdata"}, txdata, 0);
    check({tag, "_csext"}, csext, 0);
  endtask

  task automatic clear_bench();
    req = '0; spicomplete = 1'b0; spibusy = 1'b0; e_pend = 1'b0;
    for (int r = 0; r < NREQ; r++) fb_head[r] = fb_tail[r];
    model_reset();
  endtask

  initial begin
    int exp_b [7];
    int exp_c [4];
    int exp_cs [4];
    int base, n;
    bit seen;
    for (int r = 0; r < NREQ; r++) begin fb_head[r] = 0; fb_tail[r] = 0; end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // A: single word from requester 0.
    fixed_delay = 3; use_fixed_rx = 1'b1; fixed_rx = 32'h0000_1234;
    grant_log.delete(); cs_log.delete();
    push(0, 32'hA5A5_0001, 1'b1);
    run_until_idle("A_bound", 100);
    check("A_grants", grant_log.size(), 1);
    check("A_cs", cs_log.size() == 1 ? cs_log[0] : -1, 0);
    check("A_rsp_data", last_rsp_data, 32'h0000_1234);
    check("A_rsp_err", last_rsp_err, 0);

    // B: round robin between 0 and 2, then 3 joins (pointer starts at 1 here).
    use_fixed_rx = 1'b0; fixed_delay = 2;
    grant_log.delete();
    push(0, 32'h1000_0000, 1'b1); push(0, 32'h1000_0001, 1'b1);
    push(2, 32'h2000_0000, 1'b1); push(2, 32'h2000_0001, 1'b1);
    run_until_idle("B1_bound", 200);
    push(0, 32'h1000_0002, 1'b1); push(2, 32'h2000_0002, 1'b1); push(3, 32'h3000_0000, 1'b1);
    run_until_idle("B2_bound", 200);
    exp_b = '{2, 0, 2, 0, 2, 3, 0};
    check("B_count", grant_log.size(), 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("B_order%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, exp_b[k]);

    // C: three-word lock by requester 1 while requester 0 waits.
    fixed_delay = 4;
    grant_log.delete(); cs_log.delete();
    push(1, 32'hC000_0000, 1'b0); push(1, 32'hC000_0001, 1'b0); push(1, 32'hC000_0002, 1'b1);
    step(); step();
    push(0, 32'hC0C0_0000, 1'b1);
    run_until_idle("C_bound", 200);
    exp_c = '{1, 1, 1, 0};
    exp_cs = '{1, 1, 0, 0};
    check("C_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("C_order%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, exp_c[k]);
      check($sformatf("C_cs%0d", k), (k < cs_log.size()) ? cs_log[k] : -1, exp_cs[k]);
    end

    // D: timeout, followed by a late completion that must be ignored.
    fixed_delay = 21;
    base = rsp_cnt;
    push(2, 32'hD000_0000, 1'b1);
    run_until_idle("D_bound", 200);
    check("D_rsp_count", rsp_cnt - base, 1);
    check("D_rsp_err", last_rsp_err, 1);
    check("D_rsp_data", last_rsp_data, 0);

    // E: engine busy stalls issue; completion on the expiry cycle is a good word.
    force_busy = 1'b1; fixed_delay = 16;
    n = grant_log.size();
    push(0, 32'hE000_0000, 1'b1);
    repeat (10) step();
    check("E_stalled", grant_log.size() - n, 0);
    force_busy = 1'b0;
    run_until_idle("E_bound", 200);
    check("E_granted", grant_log.size() - n, 1);
    check("E_rsp_err", last_rsp_err, 0);

    // F: asynchronous reset in mid-word, then pointer back at 0.
    fixed_delay = 10;
    push(3, 32'hF000_0000, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (txstart) seen = 1'b1;
    end
    check("F_started", seen, 1'b1);
    #3 rst = 1'b1;
    #1 check_zero("async");
    clear_bench();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    fixed_delay = 2;
    grant_log.delete();
    push(3, 32'hF000_0003, 1'b1); push(0, 32'hF000_0000, 1'b1);
    run_until_idle("F_bound", 200);
    check("F_count", grant_log.size(), 2);
    check("F_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("F_second", grant_log.size() > 1 ? grant_log[1] : -1, 3);

    // Random traffic against the model.
    fixed_delay = 0; req_prob = 70; busy_prob = 10; stray_prob = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (qcount(r) == 0 && !req[r] && $urandom_range(99) < 4) begin
          n = int'($urandom_range(1, 3));
          for (int k = 0; k < n; k++) push(r, $urandom, k == n - 1);
        end
      end
      step();
    end
    req_prob = 100; busy_prob = 0; stray_prob = 0;
    run_until_idle("R_bound", 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
